dac_spi_frame_rx: RTL
=====================

// Module: dac_spi_frame_rx
// PURPOSE
//  SPI-mode frame receiver: the receive end of the 24-bit DAC SPI link. Captures frames from
//  an SPI initiator (CS active low, SCLK idles high, MSB first, data stable at SCLK fall).
//  Sits on the loopback/monitor path: shadows frames sent to the DAC, or takes commands from an
//  external controller. Presents each complete frame as a parallel word with a one-cycle valid pulse.
//  SPI pins are asynchronous to clock_in and are synchronized internally.
// PARAMETERS
//  FRAME_BITS   24  bits per frame; frame accepted only if exactly this many SCLK falls occur
//  SYNC_STAGES  2   flip-flop stages in each input synchronizer (>=2)
// PORTS
//  clock_in      in   1           system clock; must run >= 4x SCLK frequency
//  reset_n       in   1           asynchronous, active-low reset
//  spi_cs_in     in   1           chip select, active low, async
//  spi_clock_in  in   1           SPI clock, idles high, async
//  spi_data_in   in   1           serial data, sampled at SCLK falling edge, async
//  data_out      out  FRAME_BITS  last good frame; bit[FRAME_BITS-1] = first bit received
//  data_valid    out  1           one-cycle pulse: data_out updated this cycle
//  frame_error   out  1           one-cycle pulse: frame ended with wrong bit count
//  busy          out  1           high while a frame is in progress (synced CS low)
// BEHAVIOUR
//  Reset (reset_n=0, async): data_out=0, data_valid=0, frame_error=0, busy=0, state IDLE,
//   bit counter 0, shift reg 0; synchronizers preset cs=1, sclk=1, data=0 (no false edges at release).
//  Sync: cs_s, sclk_s, sdi_s = SYNC_STAGES-deep copies; one extra register on cs_s, sclk_s for
//   edge detect. sclk_fall = prev 1 & now 0; cs_fall / cs_rise likewise on cs_s.
//  Sampling: on sclk_fall while cs_s=0, shift sdi_s in at LSB (shift left); bit counter += 1.
//   Counter width clog2(FRAME_BITS+1)+1; saturates, never wraps.
//  States:
//   IDLE  : busy=0. cs_fall -> SHIFT, clear counter and shift reg. SCLK edges with cs_s=1 ignored.
//   SHIFT : busy=1. Sample as above. cs_rise: counter==FRAME_BITS -> DONE; else -> ERR.
//           cs_fall and cs_rise cannot coincide (single signal); sclk_fall in same cycle as cs_rise
//           is NOT sampled (CS deasserted takes priority).
//   DONE  : one cycle; data_out <= shift reg, data_valid=1; -> IDLE (or SHIFT if cs_s already low
//           again, with counter cleared, so back-to-back frames with CS high >=1 synced cycle work).
//   ERR   : one cycle; frame_error=1, data_out unchanged; -> IDLE/SHIFT as DONE.
//  Too many bits (>FRAME_BITS falls) and too few both end in ERR at cs_rise.
//  Latency: data_valid asserts SYNC_STAGES+2 clock_in cycles after CS pin rises (+/-1 for async).
//  data_valid and frame_error are mutually exclusive, never high two consecutive cycles.
//  Leading SCLK level at cs_fall is not checked; only falls are counted.
//  reset_n low mid-frame: frame discarded, no valid/error pulse; after release, a frame in
//   progress (CS already low) is ignored until CS goes high then low again (IDLE needs cs_fall).
// TESTING
//  1 Send 0xA5C3F0, SCLK half-period 10 clk, CS high gap 20 clk -> one data_valid, data_out=0xA5C3F0,
//    frame_error never set, busy high exactly during synced CS low.
//  2 Send 12 bits 0xFFF then CS high -> frame_error pulse 1 cycle, data_valid 0, data_out keeps
//    previous value (0xA5C3F0).
//  3 Send 25 bits (0x123456 then extra 1) -> frame_error, no data_valid, data_out unchanged.
//  4 Back-to-back 0x000001 then 0x800000, CS high 4 clk between -> two valid pulses, values in order.
//  5 Toggle SCLK 8 times and data with CS high -> no busy, no pulses; next frame 0x5A5A5A received.
//  6 Assert reset_n low after 10 bits of 0xFFFFFF, release with CS still low, finish frame ->
//    no pulses; outputs 0; next full frame 0x00FF00 -> data_valid, data_out=0x00FF00.

Source files
------------

// File: rtl/dac_spi_frame_rx.sv
// Receive end of the 24-bit DAC SPI link: synchronizes CS/SCLK/SDI and
// presents each complete frame as a parallel word with a one-cycle valid pulse.
module dac_spi_frame_rx #(
   parameter int FRAME_BITS  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   input  logic                  spi_cs_in,
   input  logic                  spi_clock_in,
   input  logic                  spi_data_in,
   output logic [FRAME_BITS-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int CW = $clog2(FRAME_BITS + 1) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE,
      ERR
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic [SYNC_STAGES:0]   primed_q, primed_d;
   logic                   cs_prev_q;
   logic                   sclk_prev_q;
   logic                   armed_q;

   logic cs_s, sclk_s, sdi_s;
   logic cs_fall, cs_rise, sclk_fall;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic [FRAME_BITS-1:0] data_q;
   logic                  valid_q;
   logic                  err_q;
   logic                  busy_q;

   assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_in};
   assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clock_in};
   assign sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_data_in};
   assign primed_d    = {primed_q[SYNC_STAGES-1:0], 1'b1};

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '1;
         sdi_sync_q  <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
         primed_q    <= '0;
         armed_q     <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
         primed_q    <= primed_d;
         // A frame already running when reset releases must see CS high first
         if (primed_q[SYNC_STAGES] && cs_s)
            armed_q <= 1'b1;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cs_fall && armed_q) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
                  shift_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  busy_q  <= 1'b0;
                  state_q <= (cnt_q == CW'(FRAME_BITS)) ? DONE : ERR;
               end else if (sclk_fall) begin
                  shift_q <= {shift_q[FRAME_BITS-2:0], sdi_s};
                  if (cnt_q != {CW{1'b1}})
                     cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE, ERR: begin
               if (state_q == DONE) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
               // CS may already be low again for a back-to-back frame
               if (!cs_s) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
                  shift_q <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_error = err_q;
   assign busy        = busy_q;

endmodule
